// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC memory subsystem: bus widths and the
// memory arbiter state encoding.
package sisc_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch vs load/store, one access in
// flight, load/store priority with a starvation override for fetch.
module mem_arbiter
    import sisc_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_f,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT     = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic busy, first_busy;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= '0;
            starve_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    // A saturated starvation count is only ever reached with
                    // if_req pending, so the increment below cannot overflow.
                    if (ls_req && !(if_req && starve_q == STARVE_MAX)) begin
                        owner_d = OWN_LS;
                        addr_d  = ls_addr;
                        we_d    = ls_we;
                        wdata_d = ls_wdata;
                        if (if_req) starve_d = starve_q + 4'd1;
                    end else begin
                        owner_d  = OWN_IF;
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end
                    cnt_d   = LAT;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
                        else                   ls_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter still holds its load value only in the first BUSY cycle.
    assign busy       = (state_q == ST_BUSY);
    assign first_busy = busy && (cnt_q == LAT);

    assign if_gnt   = first_busy && (owner_q == OWN_IF);
    assign ls_gnt   = first_busy && (owner_q == OWN_LS);
    assign if_valid = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign ls_valid = (state_q == ST_DONE) && (owner_q == OWN_LS);
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

    assign mem_en    = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected responses,
// a negedge monitor checks grants, bus activity and completions against them.
module tb_mem_arbiter;
    import sisc_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic        ls;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 0, ls_req = 0, ls_we = 0;
    logic [15:0] if_addr = 0, ls_addr = 0;
    logic [31:0] ls_wdata = 0;
    logic        if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic        b_if_req = 0, b_ls_req = 0;
    logic        b_if_gnt, b_if_valid, b_ls_gnt, b_ls_valid, b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_mem_addr;

    function automatic logic [31:0] mem_model(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hA5A5_0001 : {16'hC0DE, a};
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_arbiter #(.MEM_LAT(LAT), .MAX_STARVE(4)) u_dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(1), .MAX_STARVE(1)) u_lat1 (
        .clk(clk), .rst_f(rst_f),
        .if_req(b_if_req), .if_addr(16'h0030), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(1'b0), .ls_addr(16'h0400), .ls_wdata(32'h0),
        .ls_gnt(b_ls_gnt), .ls_valid(b_ls_valid), .ls_rdata(b_ls_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    int   n_chk = 0, n_fail = 0, cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [31:0] m_if_rd = 0, m_ls_rd = 0;
    int   busy_n = 0, gnt_cyc = -100, last_if_gnt = -100, last_ls_gnt = -100;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_req(input logic ls, input logic we, input logic [15:0] addr,
                            input logic [31:0] wdata);
        exp_t e;
        e.ls = ls; e.we = we; e.addr = addr; e.wdata = wdata;
        if (!we) begin
            if (ls) m_ls_rd = mem_model(addr);
            else    m_if_rd = mem_model(addr);
        end
        e.rdata = ls ? m_ls_rd : m_if_rd;
        q.push_back(e);
    endtask

    // Raise one requester and hold it until its valid pulse.
    task automatic run_req(input logic ls, input logic we, input logic [15:0] addr,
                           input logic [31:0] wdata);
        bit done = 0;
        if (ls) begin ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_req = 1; end
        else    begin if_addr = addr; if_req = 1; end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ls ? ls_valid : if_valid) done = 1;
        end
        if (ls) ls_req = 0; else if_req = 0;
        if (!done) flag(ls ? "ls_timeout" : "if_timeout");
    endtask

    always @(negedge clk) begin
        if (!rst_f) begin
            busy_n = 0;
        end else begin
            chk("gnt_onehot", 32'(if_gnt & ls_gnt), 32'd0);
            chk("valid_onehot", 32'(if_valid & ls_valid), 32'd0);
            if (if_gnt || ls_gnt) begin
                gnt_cyc = cyc;
                if (if_gnt) last_if_gnt = cyc; else last_ls_gnt = cyc;
                if (q.size() == 0) flag("unexpected_gnt");
                else chk("gnt_port", 32'(ls_gnt), 32'(q[0].ls));
            end
            if (mem_en) begin
                busy_n++;
                if (q.size() != 0) begin
                    chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
                    chk("mem_we", 32'(mem_we), 32'(q[0].we));
                    if (q[0].we) chk("mem_wdata", mem_wdata, q[0].wdata);
                end
            end
            if (if_valid || ls_valid) begin
                if (q.size() == 0) flag("unexpected_valid");
                else begin
                    mon_e = q.pop_front();
                    chk("valid_port", 32'(ls_valid), 32'(mon_e.ls));
                    chk("valid_latency", 32'(cyc - gnt_cyc), 32'(LAT));
                    chk("busy_cycles", 32'(busy_n), 32'(LAT));
                    chk(mon_e.ls ? "ls_rdata" : "if_rdata", mon_e.ls ? ls_rdata : if_rdata, mon_e.rdata);
                end
                busy_n = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        int t0, nls, ph;
        bit done, lsw;
        logic [3:0] expv;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'b0, if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we}, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_ls_rdata", ls_rdata, 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        rst_f = 1;
        repeat (2) @(negedge clk);

        // Lone fetch
        push_req(0, 0, 16'h0010, 0);
        t0 = cyc;
        run_req(0, 0, 16'h0010, 0);
        chk("fetch_gnt_latency", 32'(last_if_gnt - t0), 32'd1);
        chk("fetch_rdata", if_rdata, 32'hA5A5_0001);

        // Simultaneous load and fetch: load wins, fetch follows
        @(negedge clk);
        push_req(1, 0, 16'h0200, 0);
        push_req(0, 0, 16'h0020, 0);
        fork
            run_req(1, 0, 16'h0200, 0);
            run_req(0, 0, 16'h0020, 0);
        join
        chk("simul_fetch_gap", 32'(last_if_gnt - last_ls_gnt), 32'(LAT + 2));
        chk("simul_ls_rdata", ls_rdata, 32'hC0DE_0200);

        // Store leaves ls_rdata untouched
        @(negedge clk);
        push_req(1, 1, 16'h0300, 32'hDEAD_BEEF);
        run_req(1, 1, 16'h0300, 32'hDEAD_BEEF);
        chk("store_ls_rdata_kept", ls_rdata, 32'hC0DE_0200);
        chk("store_if_rdata_kept", if_rdata, 32'hC0DE_0020);

        // Starvation: two rounds of 4 loads then a forced fetch
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) push_req(1, 0, 16'h0204, 0);
            push_req(0, 0, 16'h0044, 0);
            ls_we = 0; ls_addr = 16'h0204; if_addr = 16'h0044;
            ls_req = 1; if_req = 1;
            nls = 0; done = 0;
            for (int i = 0; i < 100 && !done; i++) begin
                @(negedge clk);
                if (ls_gnt) nls++;
                if (if_gnt) ls_req = 0;
                if (if_valid) begin if_req = 0; done = 1; end
            end
            ls_req = 0; if_req = 0;
            if (!done) flag("starve_timeout");
            chk("starve_ls_grants", 32'(nls), 32'd4);
        end
        chk("starve_if_rdata", if_rdata, 32'hC0DE_0044);

        // Reset in the second BUSY cycle aborts the access
        @(negedge clk);
        push_req(0, 0, 16'h0010, 0);
        if_addr = 16'h0010; if_req = 1;
        @(negedge clk);
        chk("abort_gnt_seen", 32'(if_gnt), 32'd1);
        @(posedge clk);
        #2 rst_f = 0;
        #1;
        chk("abort_outputs", {26'b0, if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we}, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        chk("abort_ls_rdata", ls_rdata, 32'd0);
        q.delete();
        m_if_rd = 0; m_ls_rd = 0;
        if_req = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(if_valid), 32'd0);
        end
        rst_f = 1;
        repeat (4) @(negedge clk);
        push_req(0, 0, 16'h0010, 0);
        t0 = cyc;
        run_req(0, 0, 16'h0010, 0);
        chk("post_reset_gnt_latency", 32'(last_if_gnt - t0), 32'd1);
        chk("post_reset_rdata", if_rdata, 32'hA5A5_0001);

        // MEM_LAT=1 instance: alternating grants every 3 cycles
        @(negedge clk);
        b_if_req = 1; b_ls_req = 1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            ph  = (n - 1) % 3;
            lsw = (((n - 1) / 3) % 2) == 0;
            expv = {ph == 0 && !lsw, ph == 0 && lsw, ph == 1 && !lsw, ph == 1 && lsw};
            chk("lat1_pattern", 32'({b_if_gnt, b_ls_gnt, b_if_valid, b_ls_valid}), 32'(expv));
            chk("lat1_onehot", 32'((b_if_gnt & b_ls_gnt) | (b_if_valid & b_ls_valid)), 32'd0);
        end
        b_if_req = 0; b_ls_req = 0;
        chk("lat1_if_rdata", b_if_rdata, 32'hC0DE_0030);
        chk("lat1_ls_rdata", b_ls_rdata, 32'hC0DE_0400);

        repeat (4) @(negedge clk);
        if (q.size() != 0) flag("scoreboard_not_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
